// File: rtl/pipelined_adder_decoder_pkg.sv
// Shared definitions for the pipelined adder/decoder: operation modes and
// the active-low hex glyph table used by the 7-segment driver.
package adder_pkg;

    typedef enum logic [1:0] {
        MODE_ADD = 2'b00,
        MODE_SUB = 2'b01,
        MODE_SAT = 2'b10,
        MODE_ACC = 2'b11
    } mode_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Segment order {g,f,e,d,c,b,a}, a lit segment is driven low.
    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/pipelined_adder_decoder_hex_to_7seg.sv
// Combinational nibble to active-low 7-segment glyph lookup.
module hex_to_7seg
    import adder_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_GLYPH[nibble];

endmodule

// File: rtl/pipelined_adder_decoder.sv
// Two-stage add/sub/saturate/accumulate pipeline whose results are shown on a
// time-multiplexed hex 7-segment display (one carry digit above the nibbles).
module pipelined_adder_decoder
    import adder_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int NDIG      = WIDTH / 4 + 1,
    parameter int SCAN_BITS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       mode,
    input  logic             acc_clr,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             ovf,
    output logic [6:0]       seg,
    output logic [NDIG-1:0]  an
);

    localparam int SEL_W = $clog2(NDIG);

    mode_e            mode_p0;
    logic [WIDTH-1:0] acc_base_p0;
    logic [WIDTH:0]   sum_p0;

    logic             vld_p1;
    mode_e            mode_p1;
    logic [WIDTH:0]   r_p1;
    logic [WIDTH-1:0] acc;

    logic [WIDTH:0]   disp;
    logic [SCAN_BITS-1:0] scan;
    logic [SEL_W-1:0] sel;
    logic [3:0]       nib;
    logic             blank;
    logic [NDIG-1:0]  an_next;
    logic [6:0]       glyph;

    assign mode_p0 = mode_e'(mode);

    // A same-cycle clear is applied before the accumulate add.
    assign acc_base_p0 = acc_clr ? '0 : acc;

    always_comb begin
        sum_p0 = {1'b0, input1} + {1'b0, input2};
        case (mode_p0)
            MODE_SUB: sum_p0 = {1'b0, input1} - {1'b0, input2};
            MODE_ACC: sum_p0 = {1'b0, acc_base_p0} + {1'b0, input1};
            default:  sum_p0 = {1'b0, input1} + {1'b0, input2};
        endcase
    end

    // ---- stage 1: operate, update accumulator ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            mode_p1 <= MODE_ADD;
            r_p1    <= '0;
            acc     <= '0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                mode_p1 <= mode_p0;
                r_p1    <= sum_p0;
            end
            if (in_valid && mode_p0 == MODE_ACC) begin
                acc <= sum_p0[WIDTH-1:0];
            end else if (acc_clr) begin
                acc <= '0;
            end
        end
    end

    // ---- stage 2: result formatting, saturation ----
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out       <= '0;
            carry     <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= vld_p1;
            if (vld_p1) begin
                if (mode_p1 == MODE_SAT && r_p1[WIDTH]) begin
                    out   <= '1;
                    carry <= 1'b1;
                    ovf   <= 1'b1;
                end else begin
                    out   <= r_p1[WIDTH-1:0];
                    carry <= r_p1[WIDTH];
                    ovf   <= 1'b0;
                end
            end
        end
    end

    // ---- display: result latch, scan counter, registered digit drive ----
    assign sel   = scan[SCAN_BITS-1 -: SEL_W];
    assign blank = (32'(sel) >= NDIG);

    always_comb begin
        nib = {3'b000, disp[WIDTH]};
        for (int i = 0; i < NDIG - 1; i++) begin
            if (sel == SEL_W'(i)) nib = disp[4*i +: 4];
        end
        an_next = blank ? '1 : ~(NDIG'(1) << sel);
    end

    hex_to_7seg u_hex_to_7seg (
        .nibble (nib),
        .seg    (glyph)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            disp <= '0;
            scan <= '0;
            seg  <= SEG_BLANK;
            an   <= '1;
        end else begin
            if (out_valid) disp <= {carry, out};
            scan <= scan + 1'b1;
            seg  <= blank ? SEG_BLANK : glyph;
            an   <= an_next;
        end
    end

endmodule

// File: tb/tb_pipelined_adder_decoder.sv
// Randomized self-checking bench for pipelined_adder_decoder against a
// cycle-indexed behavioural model of results and display scanning.
module tb_pipelined_adder_decoder;

    localparam int WIDTH     = 4;
    localparam int SCAN_BITS = 4;
    localparam int NDIG      = WIDTH / 4 + 1;
    localparam int SEL_W     = $clog2(NDIG);
    localparam int MAXV      = 1 << WIDTH;
    localparam int ALL_AN    = (1 << NDIG) - 1;
    localparam int NCYC      = 1024;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [1:0]       mode;
    logic             acc_clr;
    logic [WIDTH-1:0] input1;
    logic [WIDTH-1:0] input2;
    logic             out_valid;
    logic [WIDTH-1:0] out;
    logic             carry;
    logic             ovf;
    logic [6:0]       seg;
    logic [NDIG-1:0]  an;

    pipelined_adder_decoder #(.WIDTH(WIDTH), .SCAN_BITS(SCAN_BITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .mode      (mode),
        .acc_clr   (acc_clr),
        .input1    (input1),
        .input2    (input2),
        .out_valid (out_valid),
        .out       (out),
        .carry     (carry),
        .ovf       (ovf),
        .seg       (seg),
        .an        (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] glyph_ref [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int n_total = 0;
    int n_bad   = 0;
    int t       = 0;

    bit e_vld [NCYC];
    bit e_rst [NCYC];
    int e_out [NCYC];
    int e_cy  [NCYC];
    int e_ov  [NCYC];

    int h_out, h_carry, h_ovf;
    int e_seg, e_an;
    int m_scan, m_disp, m_acc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, want, t);
        end
    endtask

    // Check the outputs due this cycle, advance the model, then apply one cycle of stimulus.
    task automatic step(input bit r, input bit v, input int m, input bit c, input int a, input int b);
        int s, res, cy, ov, sel, digit;
        if (e_rst[t]) begin
            h_out = 0; h_carry = 0; h_ovf = 0;
        end
        check_eq("out_valid", 32'(out_valid), 32'(e_vld[t]));
        if (e_vld[t]) begin
            h_out = e_out[t]; h_carry = e_cy[t]; h_ovf = e_ov[t];
        end
        check_eq("out", 32'(out), h_out);
        check_eq("carry", 32'(carry), h_carry);
        check_eq("ovf", 32'(ovf), h_ovf);
        check_eq("seg", 32'(seg), e_seg);
        check_eq("an", 32'(an), e_an);

        if (r) begin
            e_seg = 7'h7F; e_an = ALL_AN;
            m_scan = 0; m_disp = 0; m_acc = 0;
            e_rst[t+1] = 1'b1;
            e_vld[t+1] = 1'b0;
        end else begin
            sel = m_scan >> (SCAN_BITS - SEL_W);
            if (sel >= NDIG) begin
                e_seg = 7'h7F; e_an = ALL_AN;
            end else begin
                if (sel == NDIG - 1) digit = (m_disp >> WIDTH) & 1;
                else                 digit = (m_disp >> (4 * sel)) & 15;
                e_seg = glyph_ref[digit];
                e_an  = ALL_AN ^ (1 << sel);
            end
            if (e_vld[t]) m_disp = h_carry * MAXV + h_out;
            m_scan = (m_scan + 1) % (1 << SCAN_BITS);
            if (c) m_acc = 0;
            if (v) begin
                ov = 0;
                case (m)
                    1: begin res = (a - b + MAXV) % MAXV; cy = (a < b) ? 1 : 0; end
                    2: begin
                        s = a + b;
                        if (s >= MAXV) begin res = MAXV - 1; cy = 1; ov = 1; end
                        else begin res = s; cy = 0; end
                    end
                    3: begin s = m_acc + a; res = s % MAXV; cy = (s >= MAXV) ? 1 : 0; m_acc = res; end
                    default: begin s = a + b; res = s % MAXV; cy = (s >= MAXV) ? 1 : 0; end
                endcase
                e_vld[t+2] = 1'b1; e_out[t+2] = res; e_cy[t+2] = cy; e_ov[t+2] = ov;
            end
        end

        rst      = r;
        in_valid = v;
        mode     = m[1:0];
        acc_clr  = c;
        input1   = a[WIDTH-1:0];
        input2   = b[WIDTH-1:0];
        @(negedge clk);
        t++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < NCYC; i++) begin
            e_vld[i] = 1'b0; e_rst[i] = 1'b0; e_out[i] = 0; e_cy[i] = 0; e_ov[i] = 0;
        end
        e_rst[0] = 1'b1;
        e_seg = 7'h7F; e_an = ALL_AN;
        m_scan = 0; m_disp = 0; m_acc = 0;
        h_out = 0; h_carry = 0; h_ovf = 0;

        rst = 1'b1; in_valid = 1'b0; mode = 2'b00; acc_clr = 1'b0;
        input1 = '0; input2 = '0;
        @(negedge clk);

        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);

        step(0, 1, 0, 0, 9, 8);
        step(0, 1, 0, 0, 3, 4);
        step(0, 1, 2, 0, 9, 8);
        step(0, 1, 2, 0, 5, 6);
        step(0, 1, 1, 0, 3, 5);
        step(0, 1, 1, 0, 5, 3);
        idle(3);

        step(0, 0, 0, 1, 0, 0);
        step(0, 1, 3, 0, 5, 0);
        step(0, 1, 3, 0, 5, 0);
        step(0, 1, 3, 0, 7, 0);
        step(0, 1, 3, 1, 9, 0);
        idle(3);

        step(0, 1, 0, 0, 15, 15);
        step(0, 1, 1, 0, 0, 1);
        step(0, 1, 3, 0, 8, 0);
        step(0, 1, 2, 0, 15, 1);
        idle(4);

        for (int i = 0; i < 300; i++) begin
            step(0, ($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) == 0), int'($urandom_range(0, MAXV - 1)),
                 int'($urandom_range(0, MAXV - 1)));
        end
        idle(3);

        step(0, 1, 0, 0, 9, 8);
        step(1, 0, 0, 0, 0, 0);
        idle(4);
        step(0, 1, 0, 0, 9, 8);
        idle(40);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
